// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default framing parameters,
// common to the baud generator, transmitter and receiver.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEFAULT = 16;
    localparam int unsigned DATA_BITS_DEFAULT  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous off-chip inputs, with a parameterised
// reset value so idle-high lines do not fake an edge out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    // next values for the two stages
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // synchroniser stages
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: 16x oversampled start/data/stop sampling, LSB first,
// with one-cycle data-valid and framing-error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DATA_BITS_DEFAULT,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic                 rx_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_err,
    output logic                 busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS) + 1;
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic rx_s;

    uart_state_e          state_d, state_q;
    logic [TW-1:0]        tick_cnt_d, tick_cnt_q;
    logic [BW-1:0]        bit_cnt_d, bit_cnt_q;
    logic [DATA_BITS-1:0] shift_d, shift_q;
    logic [DATA_BITS-1:0] rx_data_d, rx_data_q;
    logic                 rx_valid_d, rx_valid_q;
    logic                 framing_err_d, framing_err_q;
    logic                 busy_d, busy_q;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // frame FSM: next state, counters, shift register and output pulses
    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        framing_err_d = 1'b0;

        if (!rx_en) begin
            state_d    = IDLE;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (rx_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    // mid-start-bit re-check rejects glitches shorter than half a bit
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_q == TICK_END) begin
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt_q == TICK_END) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            framing_err_d = 1'b1;
                            state_d       = BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                BREAK: begin
                    // a held-low line must release before another start is accepted
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = BREAK;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != IDLE);
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            framing_err_q <= framing_err_d;
            busy_q        <= busy_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign framing_err = framing_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial-line driver pushes the expected receive
// event per frame, and an independent monitor pops and compares on each output pulse.
module tb_uart_rx;

    localparam int TICK_DIV = 4;
    localparam int OS       = 16;
    localparam int BIT_CLKS = TICK_DIV * OS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_en = 1'b0;
    logic       rx_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_err;
    logic       busy;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         valid_cyc[$];
    logic [7:0] last_good = 8'h00;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         tick_div = 0;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_en       (rx_en),
        .rx_tick     (rx_tick),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .framing_err (framing_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // baud-generator stand-in: one rx_tick every TICK_DIV clocks
    initial begin
        forever begin
            @(negedge clk);
            tick_div = (tick_div + 1) % TICK_DIV;
            rx_tick = (tick_div == 0);
        end
    end

    // monitor: every output pulse must match the oldest expected event
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (rx_valid || framing_err) begin
                check("pulse_exclusive", 32'(rx_valid & framing_err), 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got valid=%0b ferr=%0b data=%0h expected no pulse (cycle %0d)",
                             rx_valid, framing_err, rx_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind_ferr", 32'(framing_err), 32'(e.err));
                    check("rx_data", 32'(rx_data), 32'(e.data));
                    if (rx_valid) valid_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // sends one frame; a bad stop leaves the line low for hold_low extra bit times
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int hold_low);
        ev_t e;
        if (stop_ok) begin
            e.err = 1'b0;
            e.data = b;
            last_good = b;
        end else begin
            e.err = 1'b1;
            e.data = last_good;
        end
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        if (!stop_ok) begin
            for (int i = 0; i < hold_low; i++) drive_bit(1'b0);
        end
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] pat;
        int d;
        int n;

        // reset state
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_framing_err", 32'(framing_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        rx_en = 1'b1;
        idle(200);

        // good frame
        send_frame(8'hA5, 1'b1, 0);
        check("a5_busy_after_stop", 32'(busy), 32'd0);
        check("a5_received", 32'(exp_q.size()), 32'd0);
        check("a5_data", 32'(rx_data), 32'hA5);
        idle(100);

        // false start: 4 ticks low then high
        rx = 1'b0;
        repeat (12) @(negedge clk);
        check("false_start_busy_high", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("false_start_busy_low", 32'(busy), 32'd0);
        idle(100);

        // framing error after a good frame
        send_frame(8'h12, 1'b1, 0);
        idle(50);
        send_frame(8'h3C, 1'b0, 3);
        check("break_busy_high", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        check("break_released_busy", 32'(busy), 32'd0);
        check("ferr_keeps_data", 32'(rx_data), 32'h12);
        check("ferr_seen", 32'(exp_q.size()), 32'd0);
        idle(100);

        // back-to-back frames
        valid_cyc.delete();
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        idle(100);
        check("b2b_count", 32'(valid_cyc.size()), 32'd2);
        if (valid_cyc.size() == 2) begin
            d = valid_cyc[1] - valid_cyc[0];
            check("b2b_spacing_ok", 32'(d >= 10 * BIT_CLKS - TICK_DIV && d <= 10 * BIT_CLKS + TICK_DIV), 32'd1);
        end

        // reset during bit 3 of 0x5A; the line is abandoned high afterwards
        pat = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(pat[i]);
        rx = pat[3];
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        check("midreset_rx_data", 32'(rx_data), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_valid", 32'(rx_valid), 32'd0);
        idle(200);
        send_frame(8'hC3, 1'b1, 0);
        idle(50);
        check("after_reset_data", 32'(rx_data), 32'hC3);

        // rx_en dropped during the data bits of 0x81
        pat = 8'h81;
        drive_bit(1'b0);
        for (int i = 0; i < 2; i++) drive_bit(pat[i]);
        rx = pat[2];
        repeat (20) @(negedge clk);
        rx_en = 1'b0;
        @(negedge clk);
        check("rx_en_low_busy", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        idle(200);
        rx_en = 1'b1;
        idle(100);
        send_frame(8'h7E, 1'b1, 0);
        idle(50);
        check("after_en_data", 32'(rx_data), 32'h7E);

        // randomized frames, gaps and framing errors
        for (int k = 0; k < 40; k++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                send_frame(rb, 1'b0, $urandom_range(0, 2));
                idle(BIT_CLKS + $urandom_range(0, 20));
            end else begin
                send_frame(rb, 1'b1, 0);
                n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 100);
                idle(n);
            end
        end
        idle(100);

        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_scoreboard", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
